// File: rtl/acg_pkg.sv
// Shared types and constants for the automatic clock-gate controller.
// Holds the per-group FSM state type and the idle-counter sizing.
package acg_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      OFF   = 2'd2
   } acg_state_t;

   localparam int unsigned IDLE_W   = 8;
   localparam int unsigned HOLD_MAX = (1 << IDLE_W) - 1;

endpackage

// File: rtl/acg_icg_cell.sv
// Latch-based integrated clock gate with asynchronous active-low clear.
// Kept as its own module so synthesis can swap in a library ICG cell.
module acg_icg_cell (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic gclk_o
);

   logic en_latch;

   // Transparent while the clock is low, so the enable cannot change during the high phase.
   always_latch begin
      if (!rst_ni) begin
         en_latch = 1'b0;
      end else if (!clk_i) begin
         en_latch = en_i;
      end
   end

   assign gclk_o = clk_i & en_latch;

endmodule

// File: rtl/auto_clock_gate_ctrl.sv
// Per-group clock-gating controller: hold-off FSM, ICG and saturating
// gated-cycle statistics with a registered, group-selected readout.
module auto_clock_gate_ctrl
   import acg_pkg::*;
#(
   parameter int unsigned N_GRP = 5,
   parameter int unsigned HOLD  = 3,
   parameter int unsigned CNT_W = 16,
   localparam int unsigned SEL_W = (N_GRP > 1) ? $clog2(N_GRP) : 1
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [N_GRP-1:0] En,
   input  logic             TEST_EN,
   input  logic [SEL_W-1:0] SEL,
   input  logic             STAT_CLR,
   output logic [N_GRP-1:0] GCLK,
   output logic [N_GRP-1:0] GATED,
   output logic [CNT_W-1:0] STAT
);

   localparam logic [IDLE_W-1:0] HoldIdle = IDLE_W'((HOLD > HOLD_MAX) ? HOLD_MAX : HOLD);
   localparam logic [CNT_W-1:0]  CntMax   = '1;

   logic [N_GRP-1:0][CNT_W-1:0] cnt_all;

   for (genvar g = 0; g < N_GRP; g++) begin : g_grp
      acg_state_t        state_q;
      logic [IDLE_W-1:0] idle_q;
      logic [IDLE_W-1:0] idle_nxt;
      logic              gated_q;
      logic [CNT_W-1:0]  cnt_q;
      logic              en_int;

      assign en_int   = En[g] | (state_q != OFF) | TEST_EN;
      assign idle_nxt = idle_q + IDLE_W'(1);

      // idle_q counts idle edges already seen; the HOLD-th idle edge moves to OFF,
      // so the clock runs for exactly HOLD edges after the request drops.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            state_q <= OFF;
            idle_q  <= '0;
            gated_q <= 1'b1;
         end else begin
            unique case (state_q)
               RUN: begin
                  if (!En[g]) begin
                     idle_q <= IDLE_W'(1);
                     if (HoldIdle <= IDLE_W'(1)) begin
                        state_q <= OFF;
                        gated_q <= 1'b1;
                     end else begin
                        state_q <= DRAIN;
                     end
                  end
               end
               DRAIN: begin
                  if (En[g]) begin
                     state_q <= RUN;
                     idle_q  <= '0;
                  end else if (idle_nxt == HoldIdle) begin
                     state_q <= OFF;
                     gated_q <= 1'b1;
                  end else begin
                     idle_q <= idle_nxt;
                  end
               end
               OFF: begin
                  if (En[g]) begin
                     state_q <= RUN;
                     idle_q  <= '0;
                     gated_q <= 1'b0;
                  end
               end
               default: begin
                  state_q <= OFF;
                  idle_q  <= '0;
                  gated_q <= 1'b1;
               end
            endcase
         end
      end

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            cnt_q <= '0;
         end else if (STAT_CLR) begin
            cnt_q <= '0;
         end else if (!en_int && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end

      assign cnt_all[g] = cnt_q;
      assign GATED[g]   = gated_q;

      acg_icg_cell u_icg (
         .clk_i  (CLK),
         .rst_ni (RST_N),
         .en_i   (en_int),
         .gclk_o (GCLK[g])
      );
   end

   logic [CNT_W-1:0] stat_d, stat_q;

   // Out-of-range selects match no group and read back as zero.
   always_comb begin
      stat_d = '0;
      for (int unsigned i = 0; i < N_GRP; i++) begin
         if (SEL == SEL_W'(i)) begin
            stat_d = cnt_all[i];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stat_q <= '0;
      end else begin
         stat_q <= stat_d;
      end
   end

   assign STAT = stat_q;

endmodule
